// File: rtl/lcd_rgb_receiver.sv
// RGB565 parallel-LCD receiver: measures hsync/vsync timing, locks onto the
// expected frame geometry and emits pixels tagged with their column and row.
`timescale 1ns/1ps
module lcd_rgb_receiver #(
    parameter int EXP_WIDTH   = 480,
    parameter int EXP_HEIGHT  = 272,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_res_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [15:0] i_lcd_data,
    output logic        o_pix_valid,
    output logic [9:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic [15:0] o_pix_data,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_err_hwidth,
    output logic        o_err_vheight,
    output logic [9:0]  o_h_period,
    output logic [8:0]  o_v_period
);

    typedef enum logic [1:0] { ST_SEARCH, ST_SYNC, ST_LOCKED } state_e;

    localparam int         G_W   = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam logic [9:0] EXP_W = 10'(EXP_WIDTH);
    localparam logic [8:0] EXP_H = 9'(EXP_HEIGHT);

    // Input capture (stage 1) and one-cycle history (stage 2) for edge detection
    logic        hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
    logic [15:0] data1_q;

    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge value of its neighbours, giving a true two-stage pipeline.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            de1_q   <= 1'b0;
            data1_q <= '0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            de2_q   <= 1'b0;
        end else begin
            hs1_q   <= i_hsync;
            vs1_q   <= i_vsync;
            de1_q   <= i_de;
            data1_q <= i_lcd_data;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            de2_q   <= de1_q;
        end
    end

    logic h_fall, v_fall, de_fall;
    assign h_fall  = hs2_q & ~hs1_q;
    assign v_fall  = vs2_q & ~vs1_q;
    assign de_fall = de2_q & ~de1_q;

    logic [9:0]     hcnt_q, hcnt_d, x_q, x_d, h_period_q, h_period_d;
    logic [8:0]     vcnt_q, vcnt_d, y_q, y_d, v_period_q, v_period_d;
    logic [9:0]     hcnt_inc, x_inc;
    logic [8:0]     vcnt_inc, y_inc, y_close;
    logic           bad_q, bad_d;
    state_e         state_q, state_d;
    logic [G_W-1:0] g_q, g_d;
    logic           searching, width_err, height_err, frame_good;

    assign hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + 10'd1;
    assign x_inc    = (x_q == '1)    ? x_q    : x_q + 10'd1;
    assign vcnt_inc = (vcnt_q == '1) ? vcnt_q : vcnt_q + 9'd1;
    assign y_inc    = (y_q == '1)    ? y_q    : y_q + 9'd1;

    // A line whose DE falls together with vsync still belongs to the closing frame
    assign y_close    = de_fall ? y_inc : y_q;
    assign searching  = (state_q == ST_SEARCH);
    assign width_err  = de_fall && (x_q != EXP_W) && !searching;
    assign height_err = v_fall && (y_close != EXP_H) && !searching;
    assign frame_good = !(bad_q || width_err) && (y_close == EXP_H);

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        hcnt_d     = hcnt_inc;
        h_period_d = h_period_q;
        if (h_fall) begin
            h_period_d = hcnt_q;
            hcnt_d     = 10'd1;
        end

        vcnt_d     = h_fall ? vcnt_inc : vcnt_q;
        v_period_d = v_period_q;
        if (v_fall) begin
            v_period_d = vcnt_q;
            vcnt_d     = h_fall ? 9'd1 : 9'd0;
        end

        x_d = de1_q ? x_inc : x_q;
        if (h_fall) x_d = '0;

        y_d = y_close;
        if (v_fall) y_d = '0;

        bad_d = bad_q | width_err;
        if (v_fall) bad_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        if (v_fall) begin
            unique case (state_q)
                ST_SEARCH: begin
                    state_d = ST_SYNC;
                    g_d     = '0;
                end
                ST_SYNC: begin
                    if (frame_good) begin
                        g_d = g_q + 1'b1;
                        if (int'(g_q) + 1 >= LOCK_FRAMES) state_d = ST_LOCKED;
                    end else begin
                        g_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        state_d = ST_SYNC;
                        g_d     = '0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    g_d     = '0;
                end
            endcase
        end
    end

    logic        pv_a_q, pix_valid_q;
    logic [9:0]  px_a_q, pix_x_q;
    logic [8:0]  py_a_q, pix_y_q;
    logic [15:0] pd_a_q, pix_data_q;
    logic        frame_start_q, locked_q, err_h_q, err_v_q;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            h_period_q    <= '0;
            v_period_q    <= '0;
            bad_q         <= 1'b0;
            state_q       <= ST_SEARCH;
            g_q           <= '0;
            pv_a_q        <= 1'b0;
            px_a_q        <= '0;
            py_a_q        <= '0;
            pd_a_q        <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            h_period_q    <= h_period_d;
            v_period_q    <= v_period_d;
            bad_q         <= bad_d;
            state_q       <= state_d;
            g_q           <= g_d;
            // Pixel tags are the pre-increment counters; a second register
            // stage sets the input-to-output pixel latency.
            pv_a_q        <= de1_q & ~searching;
            px_a_q        <= x_q;
            py_a_q        <= y_q;
            pd_a_q        <= data1_q;
            pix_valid_q   <= pv_a_q;
            pix_x_q       <= px_a_q;
            pix_y_q       <= py_a_q;
            pix_data_q    <= pd_a_q;
            frame_start_q <= v_fall;
            locked_q      <= (state_d == ST_LOCKED);
            err_h_q       <= width_err;
            err_v_q       <= height_err;
        end
    end

    assign o_pix_valid   = pix_valid_q;
    assign o_pix_x       = pix_x_q;
    assign o_pix_y       = pix_y_q;
    assign o_pix_data    = pix_data_q;
    assign o_frame_start = frame_start_q;
    assign o_locked      = locked_q;
    assign o_err_hwidth  = err_h_q;
    assign o_err_vheight = err_v_q;
    assign o_h_period    = h_period_q;
    assign o_v_period    = v_period_q;

endmodule

// File: doc/lcd_rgb_receiver.md
LCD_RGB_RECEIVER -- requirements
Module: lcd_rgb_receiver

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 480, expected DE-high pixels per active line.
REQ-002 SHALL have parameter EXP_HEIGHT, default 272, expected active lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required for lock.
REQ-004 SHALL have ports, in order:
- i_clk  in  1  pixel clock; single clock domain.
- i_res_n  in  1  reset; asynchronous, active-low.
- i_hsync  in  1  line sync, active-low pulse.
- i_vsync  in  1  frame sync, active-low pulse.
- i_de  in  1  data enable, active-high.
- i_lcd_data  in  16  RGB565 pixel.
- o_pix_valid  out  1  pixel strobe.
- o_pix_x  out  10  pixel column.
- o_pix_y  out  9  pixel row.
- o_pix_data  out  16  pixel value.
- o_frame_start  out  1  one-cycle pulse at each vsync fall.
- o_locked  out  1  timing lock status.
- o_err_hwidth  out  1  one-cycle pulse, bad line width.
- o_err_vheight  out  1  one-cycle pulse, bad frame height.
- o_h_period  out  10  measured clocks per line.
- o_v_period  out  9  measured lines per frame.

Function
REQ-005 SHALL register all four inputs in stage 1, then hold stage-1 hsync/vsync/de one more cycle for edge detection; a fall is previous=1 and current=0.
REQ-006 SHALL drive all outputs from registers; pixel on inputs at rising edge N appears on o_pix_* after rising edge N+2.
REQ-007 SHALL count clocks between hsync falls; at each fall it loads the count into o_h_period and restarts at 1. For a 531-clock line it reports 531. Count saturates at 1023.
REQ-008 SHALL count hsync falls between vsync falls; at each vsync fall it loads the count into o_v_period and restarts at 0, or at 1 if an hsync fall occurs in the same cycle. Count saturates at 511.
REQ-009 SHALL keep column counter x: reset to 0 at hsync fall; +1 per stage-1 DE-high cycle; saturate at 1023.
REQ-010 SHALL keep active-line counter y: reset to 0 at vsync fall; +1 at each DE fall; saturate at 511.
REQ-011 SHALL assert o_pix_valid only when stage-1 DE=1 and state is not SEARCH; o_pix_x/o_pix_y carry the x/y counter values before the increment, so the first pixel is (0,0).
REQ-012 SHALL pulse o_err_hwidth at a DE fall when x != EXP_WIDTH and state is not SEARCH; the frame is then marked bad.
REQ-013 SHALL pulse o_err_vheight at a vsync fall when y != EXP_HEIGHT and state is not SEARCH.
REQ-014 SHALL pulse o_frame_start on every vsync fall, in every state.
REQ-015 SHALL implement FSM SEARCH/SYNC/LOCKED with good-frame counter g:
- SEARCH: at vsync fall -> SYNC, g=0.
- SYNC: at vsync fall, good frame -> g+1; g reaching LOCK_FRAMES -> LOCKED. Bad frame -> g=0, stay in SYNC.
- LOCKED: at vsync fall, bad frame -> SYNC, g=0.
REQ-016 SHALL take a frame as good when it had no width error and y == EXP_HEIGHT at the closing vsync fall.
REQ-017 SHALL clear the bad-frame flag at every vsync fall.
REQ-018 SHALL drive o_locked=1 exactly while state is LOCKED, updated on the cycle after the deciding vsync fall.
REQ-019 SHALL, when a DE fall and a vsync fall occur in the same cycle, evaluate the width check first and count that line into the closing frame's y.

Reset
REQ-020 SHALL, while i_res_n=0, clear all outputs and counters to 0 and set state to SEARCH.
REQ-021 SHALL reset the sync history registers to 1 and the DE history registers to 0, so no edge is detected on the first cycles after reset.
REQ-022 SHALL treat reset mid-frame as a full restart: no error pulses until the first vsync fall after reset.

Verification
REQ-023 SHALL cover nominal stream (531 clk/line, 288 lines, hsync 1 clk, vsync 10 lines, DE 480 clk on lines 12-283): o_locked=1 one cycle after the 3rd vsync fall; o_h_period=531; o_v_period=288; no error pulses.
REQ-024 SHALL cover pixel mapping while locked: first pixel 16'hF800 -> o_pix_valid=1, o_pix_x=0, o_pix_y=0, data F800 two cycles later; last pixel -> x=479, y=271.
REQ-025 SHALL cover a single 479-clock DE line while locked -> one o_err_hwidth pulse at its DE fall; o_locked=0 after the next vsync fall; relock after 2 further good frames.
REQ-026 SHALL cover a frame with 271 active lines -> o_err_vheight pulse at the closing vsync fall; g=0.
REQ-027 SHALL cover reset asserted mid-line while locked -> all outputs 0; after release, no err pulse at the first vsync fall, state SYNC.
REQ-028 SHALL cover hsync and vsync falling in the same cycle -> o_v_period loads the prior count; the new frame's line count starts at 1; o_frame_start pulses once.
